// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction memory / fetch / decode block:
//   fmt_e     - RV32I instruction format reported by the decoder
//   fault_e   - fetch fault code attached to every decoded instruction
//   state_e   - RUN / LOAD mode of the memory controller
//   OP_*      - RV32I base opcodes recognised by the decoder
//   NOP_INSTR - canonical NOP (addi x0, x0, 0) substituted on fetch faults
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2,
        FAULT_ILLEGAL  = 2'd3
    } fault_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_decode_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_decode_if
// Fetch request channel (f_*) and decoded-instruction channel (d_*) between the
// PC generator / decode consumer (master) and the instruction memory (slave).
//   f_valid, f_pc        master -> slave   fetch request, byte address
//   f_ready              slave  -> master  request accepted when valid & ready
//   d_valid, d_*         slave  -> master  registered decoded instruction
//   d_ready              master -> slave   consumer accepts d_*
// -----------------------------------------------------------------------------
interface imem_fetch_decode_if;
    import imem_pkg::*;

    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_ready;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [31:0] d_imm;
    logic [6:0]  d_opcode;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    fmt_e        d_fmt;
    fault_e      d_fault;

    modport master (
        output f_valid, f_pc, d_ready,
        input  f_ready, d_valid, d_pc, d_instr, d_imm, d_opcode,
               d_rd, d_rs1, d_rs2, d_funct3, d_funct7, d_fmt, d_fault
    );

    modport slave (
        input  f_valid, f_pc, d_ready,
        output f_ready, d_valid, d_pc, d_instr, d_imm, d_opcode,
               d_rd, d_rs1, d_rs2, d_funct3, d_funct7, d_fmt, d_fault
    );

endinterface

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I format classifier and immediate generator.
//   instr   in   32  instruction word
//   fmt     out  3   format (FMT_BAD for opcodes outside the base set)
//   imm     out  32  sign-extended immediate (0 for R and BAD)
//   illegal out  1   opcode not recognised
// -----------------------------------------------------------------------------
module imm_gen
    import imem_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_e        fmt,
    output logic [31:0] imm,
    output logic        illegal
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        fmt     = FMT_BAD;
        imm     = '0;
        illegal = 1'b0;
        case (instr[6:0])
            OP_OP: begin
                fmt = FMT_R;
            end
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imem_fetch_decode.sv
// -----------------------------------------------------------------------------
// imem_fetch_decode
// Instruction memory with a sequential program loader, a valid/ready fetch
// port and a registered RV32I decode stage.
//   DEPTH     words stored (power of two, 16..65536)
//   RESET_PC  d_pc value after reset
//   clk, rst  clock, asynchronous active-high reset
//   ld_en     load mode request (RUN <-> LOAD)
//   ld_valid  upload word strobe, ld_data written at ld_count
//   ld_count  words written since entering LOAD
//   ld_ovf    sticky: write attempted with the memory full
//   bus       fetch request / decoded instruction channels (slave side)
// -----------------------------------------------------------------------------
module imem_fetch_decode
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_en,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_data,
    output logic [$clog2(DEPTH):0] ld_count,
    output logic                   ld_ovf,
    imem_fetch_decode_if.slave     bus
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    state_e        state;
    logic [31:0]   mem [DEPTH];

    // Output register
    logic          d_valid_q;
    logic [31:0]   d_pc_q;
    logic [31:0]   d_instr_q;
    logic [31:0]   d_imm_q;
    fmt_e          d_fmt_q;
    fault_e        d_fault_q;

    // Fetch-side combinational decode
    logic [AW-1:0] rd_addr;
    logic          misaligned;
    logic          out_of_range;
    logic [31:0]   fetch_instr;
    fmt_e          fetch_fmt;
    logic [31:0]   fetch_imm;
    logic          fetch_illegal;
    fault_e        fetch_fault;
    logic          accept;
    logic          mem_full;
    logic          mem_we;

    assign rd_addr      = bus.f_pc[AW+1:2];
    assign misaligned   = (bus.f_pc[1:0] != 2'b00);
    // DEPTH is a power of two, so any set bit above the index field is out of range.
    assign out_of_range = |bus.f_pc[31:AW+2];

    // Address faults replace the word with a NOP so downstream sees a harmless
    // instruction; an illegal opcode keeps the raw word for the trap handler.
    assign fetch_instr  = (misaligned || out_of_range) ? NOP_INSTR : mem[rd_addr];

    imm_gen u_imm_gen (
        .instr   (fetch_instr),
        .fmt     (fetch_fmt),
        .imm     (fetch_imm),
        .illegal (fetch_illegal)
    );

    always_comb begin
        fetch_fault = FAULT_NONE;
        if (misaligned) begin
            fetch_fault = FAULT_MISALIGN;
        end else if (out_of_range) begin
            fetch_fault = FAULT_RANGE;
        end else if (fetch_illegal) begin
            fetch_fault = FAULT_ILLEGAL;
        end
    end

    assign bus.f_ready = (state == ST_RUN) && (!d_valid_q || bus.d_ready);
    assign accept      = bus.f_valid && bus.f_ready;

    assign mem_full    = (ld_count == FULL);
    assign mem_we      = (state == ST_LOAD) && ld_valid && !mem_full;

    // NOTE: the storage array has no reset branch; clearing thousands of words
    // on reset would force flops instead of RAM, and the loader fills it anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ld_count[AW-1:0]] <= ld_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ld_count  <= '0;
            ld_ovf    <= 1'b0;
            d_valid_q <= 1'b0;
            d_pc_q    <= RESET_PC;
            d_instr_q <= '0;
            d_imm_q   <= '0;
            d_fmt_q   <= FMT_R;
            d_fault_q <= FAULT_NONE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        d_valid_q <= 1'b1;
                        d_pc_q    <= bus.f_pc;
                        d_instr_q <= fetch_instr;
                        d_imm_q   <= fetch_imm;
                        d_fmt_q   <= fetch_fmt;
                        d_fault_q <= fetch_fault;
                    end else if (bus.d_ready) begin
                        d_valid_q <= 1'b0;
                    end
                    if (ld_en) begin
                        state    <= ST_LOAD;
                        ld_count <= '0;
                        ld_ovf   <= 1'b0;
                        // A fetch accepted on the entry edge survives one cycle;
                        // the LOAD state flushes it on the following edge.
                        if (!accept) begin
                            d_valid_q <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    d_valid_q <= 1'b0;
                    if (ld_valid) begin
                        if (mem_full) begin
                            ld_ovf <= 1'b1;
                        end else begin
                            ld_count <= ld_count + CW'(1);
                        end
                    end
                    if (!ld_en) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.d_valid  = d_valid_q;
    assign bus.d_pc     = d_pc_q;
    assign bus.d_instr  = d_instr_q;
    assign bus.d_imm    = d_imm_q;
    assign bus.d_fmt    = d_fmt_q;
    assign bus.d_fault  = d_fault_q;
    assign bus.d_opcode = d_instr_q[6:0];
    assign bus.d_rd     = d_instr_q[11:7];
    assign bus.d_funct3 = d_instr_q[14:12];
    assign bus.d_rs1    = d_instr_q[19:15];
    assign bus.d_rs2    = d_instr_q[24:20];
    assign bus.d_funct7 = d_instr_q[31:25];

endmodule

// File: tb/tb_imem_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_decode
// Directed bench: a vector table for the pipelined fetch path plus hand-written
// sequences for back-pressure, illegal opcodes, load/fetch overlap, overflow
// and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_imem_fetch_decode;
    import imem_pkg::*;

    localparam int          DEPTH    = 16;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic [CW-1:0] ld_count;
    logic          ld_ovf;

    imem_fetch_decode_if bus ();

    imem_fetch_decode #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_count (ld_count),
        .ld_ovf   (ld_ovf),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [1:0]  fault;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        ld_valid = 1'b1;
        ld_data  = w;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " d_valid"},  32'(bus.d_valid),  32'd1);
        check({tag, " d_pc"},     bus.d_pc,          v.pc);
        check({tag, " d_instr"},  bus.d_instr,       v.instr);
        check({tag, " d_imm"},    bus.d_imm,         v.imm);
        check({tag, " d_fmt"},    32'(bus.d_fmt),    32'(v.fmt));
        check({tag, " d_fault"},  32'(bus.d_fault),  32'(v.fault));
        check({tag, " d_opcode"}, 32'(bus.d_opcode), 32'(v.instr[6:0]));
        check({tag, " d_rd"},     32'(bus.d_rd),     32'(v.rd));
        check({tag, " d_rs1"},    32'(bus.d_rs1),    32'(v.rs1));
        check({tag, " d_rs2"},    32'(bus.d_rs2),    32'(v.rs2));
        check({tag, " d_funct3"}, 32'(bus.d_funct3), 32'(v.funct3));
        check({tag, " d_funct7"}, 32'(bus.d_funct7), 32'(v.funct7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pc      instr         imm           fmt  flt rd  rs1 rs2 f3 f7
        vecs[0] = '{32'h0,  32'h00500093, 32'd5,        3'd1, 2'd0, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00};
        vecs[1] = '{32'h4,  32'h00A00113, 32'd10,       3'd1, 2'd0, 5'd2,  5'd0, 5'd10, 3'd0, 7'h00};
        vecs[2] = '{32'h8,  32'h002081B3, 32'd0,        3'd0, 2'd0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00};
        // B-type: imm[12|11|10:5|4:1] = 1|1|111111|1110 -> -4
        vecs[3] = '{32'hC,  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 2'd0, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F};
        vecs[4] = '{32'h6,  32'h00000013, 32'd0,        3'd1, 2'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00};
        vecs[5] = '{32'h40, 32'h00000013, 32'd0,        3'd1, 2'd2, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00};

        bus.f_valid = 1'b0;
        bus.f_pc    = '0;
        bus.d_ready = 1'b1;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst d_valid",  32'(bus.d_valid), 32'd0);
        check("rst d_pc",     bus.d_pc,         RESET_PC);
        check("rst d_instr",  bus.d_instr,      32'd0);
        check("rst d_imm",    bus.d_imm,        32'd0);
        check("rst d_fault",  32'(bus.d_fault), 32'd0);
        check("rst ld_count", 32'(ld_count),    32'd0);
        check("rst ld_ovf",   32'(ld_ovf),      32'd0);
        check("rst f_ready",  32'(bus.f_ready), 32'd1);

        // ---- program load
        ld_en = 1'b1;
        tick();
        check("load f_ready", 32'(bus.f_ready), 32'd0);
        for (int i = 0; i < 4; i++) load_word(vecs[i].instr);
        check("load ld_count", 32'(ld_count), 32'd4);
        ld_en = 1'b0;
        tick();
        check("run f_ready", 32'(bus.f_ready), 32'd1);

        // ---- back-to-back fetches from the vector table
        for (int i = 0; i < 6; i++) begin
            bus.f_valid = 1'b1;
            bus.f_pc    = vecs[i].pc;
            tick();
            check_vec($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("vec%0d f_ready", i), 32'(bus.f_ready), 32'd1);
        end
        bus.f_valid = 1'b0;
        tick();
        check("idle d_valid", 32'(bus.d_valid), 32'd0);

        // ---- back-pressure: hold two cycles, then the pending fetch goes in
        bus.f_valid = 1'b1;
        bus.f_pc    = 32'h0;
        tick();
        bus.d_ready = 1'b0;
        bus.f_pc    = 32'h4;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp f_ready", 32'(bus.f_ready), 32'd0);
            tick();
            check_vec($sformatf("bp hold%0d", i), vecs[0]);
        end
        bus.d_ready = 1'b1;
        #1;
        check("bp f_ready back", 32'(bus.f_ready), 32'd1);
        tick();
        check_vec("bp next", vecs[1]);
        bus.f_valid = 1'b0;
        tick();

        // ---- illegal opcode keeps the raw word
        ld_en = 1'b1;
        tick();
        load_word(32'hFFFF_FFFF);
        ld_en = 1'b0;
        tick();
        bus.f_valid = 1'b1;
        bus.f_pc    = 32'h0;
        tick();
        bus.f_valid = 1'b0;
        check("ill d_fault", 32'(bus.d_fault), 32'd3);
        check("ill d_fmt",   32'(bus.d_fmt),   32'd6);
        check("ill d_imm",   bus.d_imm,        32'd0);
        check("ill d_instr", bus.d_instr,      32'hFFFF_FFFF);
        check("ill d_rd",    32'(bus.d_rd),    32'd31);
        tick();
        check("ill drain d_valid", 32'(bus.d_valid), 32'd0);

        // ---- ld_en and fetch in the same cycle
        bus.f_valid = 1'b1;
        bus.f_pc    = 32'h4;
        ld_en       = 1'b1;
        tick();
        bus.f_valid = 1'b0;
        check("ovl d_valid",  32'(bus.d_valid), 32'd1);
        check("ovl d_pc",     bus.d_pc,         32'h4);
        check("ovl d_instr",  bus.d_instr,      32'h00A00113);
        check("ovl ld_count", 32'(ld_count),    32'd0);
        check("ovl f_ready",  32'(bus.f_ready), 32'd0);
        tick();
        check("ovl flushed", 32'(bus.d_valid), 32'd0);

        // ---- overflow: DEPTH+1 writes
        for (int i = 0; i <= DEPTH; i++) load_word(32'h1000 + 32'(i));
        check("ovf ld_count", 32'(ld_count), 32'(DEPTH));
        check("ovf ld_ovf",   32'(ld_ovf),   32'd1);
        ld_en = 1'b0;
        tick();
        check("ovf sticky", 32'(ld_ovf), 32'd1);
        ld_en = 1'b1;
        tick();
        check("reload ld_ovf",   32'(ld_ovf),   32'd0);
        check("reload ld_count", 32'(ld_count), 32'd0);

        // ---- reset mid-LOAD
        load_word(32'h00700193);
        load_word(32'h00800213);
        check("midload ld_count", 32'(ld_count), 32'd2);
        #2;
        rst   = 1'b1;
        ld_en = 1'b0;
        #1;
        check("midload rst ld_count", 32'(ld_count), 32'd0);
        check("midload rst f_ready",  32'(bus.f_ready), 32'd1);
        rst = 1'b0;
        tick();

        // ---- reset while d_valid is held
        bus.d_ready = 1'b0;
        bus.f_valid = 1'b1;
        bus.f_pc    = 32'h0;
        tick();
        bus.f_valid = 1'b0;
        check("kept word0 d_instr", bus.d_instr,      32'h00700193);
        check("kept word0 d_imm",   bus.d_imm,        32'd7);
        check("held d_valid",       32'(bus.d_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst d_valid", 32'(bus.d_valid), 32'd0);
        check("async rst d_pc",    bus.d_pc,         RESET_PC);
        check("async rst d_instr", bus.d_instr,      32'd0);
        rst         = 1'b0;
        bus.d_ready = 1'b1;
        tick();
        bus.f_valid = 1'b1;
        bus.f_pc    = 32'h4;
        tick();
        bus.f_valid = 1'b0;
        check("kept word1 d_instr", bus.d_instr,   32'h00800213);
        check("kept word1 d_imm",   bus.d_imm,     32'd8);
        check("kept word1 d_rd",    32'(bus.d_rd), 32'd4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
